// File: rtl/pwm_timing_generator_if.sv
// Sample stream in, shared PWM tick count in, per-transducer PWM bits and frame-update pulse out.
// The master drives samples and the tick count; the slave (timing generator) drives PWM outputs.
interface pwm_timing_generator_if #(
    parameter int DEPTH = 249
);
    logic [8:0]       pwm_time;
    logic             din_vld;
    logic [8:0]       pulse_width_in;
    logic [7:0]       phase_in;
    logic [DEPTH-1:0] pwm_out;
    logic             updated;

    modport master (
        output pwm_time, din_vld, pulse_width_in, phase_in,
        input  pwm_out, updated
    );

    modport slave (
        input  pwm_time, din_vld, pulse_width_in, phase_in,
        output pwm_out, updated
    );
endinterface

// File: rtl/pwm_timing_generator.sv
// Converts (pulse width, phase) frames into double-buffered rise/fall edges and drives one PWM bit per transducer.
// Latency: sample lands in shadow 2 cycles after din_vld; PWM bits lag pwm_time by 1 cycle; new frame shows at next pwm_time==0.
// Backpressure: none, a sample is accepted on every cycle din_vld is high.
module pwm_timing_generator #(
    parameter int DEPTH = 249
) (
    input  logic                  clk,
    input  logic                  rst,
    pwm_timing_generator_if.slave bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    typedef logic [8:0] tick_t;

    // Stage 1 registers
    logic            s1_vld_q,  s1_vld_d;
    tick_t           s1_rise_q, s1_rise_d;
    tick_t           s1_fall_q, s1_fall_d;

    // Frame bookkeeping
    logic [IW-1:0]   idx_q,     idx_d;
    logic            pending_q, pending_d;

    // Double-buffered edge tables
    tick_t           shadow_rise_q [DEPTH];
    tick_t           shadow_rise_d [DEPTH];
    tick_t           shadow_fall_q [DEPTH];
    tick_t           shadow_fall_d [DEPTH];
    tick_t           active_rise_q [DEPTH];
    tick_t           active_rise_d [DEPTH];
    tick_t           active_fall_q [DEPTH];
    tick_t           active_fall_d [DEPTH];

    logic [DEPTH-1:0] pwm_out_q, pwm_out_d;
    logic             updated_q, updated_d;

    tick_t pw_sat;
    tick_t pw_half_dn;
    tick_t pw_half_up;
    tick_t phase_ticks;
    logic  swap;

    function automatic logic edge_hit(input tick_t r, input tick_t f, input tick_t t);
        logic hit;
        if (r < f) begin
            hit = (t >= r) && (t < f);
        end else if (r > f) begin
            hit = (t >= r) || (t < f);
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

    // Edge arithmetic: the pulse is centred on 2*phase, high for exactly pw ticks.
    always_comb begin
        pw_sat      = (bus.pulse_width_in > 9'd256) ? 9'd256 : bus.pulse_width_in;
        pw_half_dn  = pw_sat >> 1;
        pw_half_up  = (pw_sat + 9'd1) >> 1;
        phase_ticks = {bus.phase_in, 1'b0};

        s1_vld_d  = bus.din_vld;
        s1_rise_d = s1_rise_q;
        s1_fall_d = s1_fall_q;
        if (bus.din_vld) begin
            s1_rise_d = phase_ticks - pw_half_dn;
            s1_fall_d = phase_ticks + pw_half_up;
        end
    end

    // A write at index 0 drops any completed-but-unswapped frame; the last write of a frame
    // arms the swap, and that takes priority over a same-cycle swap clearing pending.
    always_comb begin
        swap          = (bus.pwm_time == 9'd0) && pending_q;
        idx_d         = idx_q;
        pending_d     = pending_q;
        shadow_rise_d = shadow_rise_q;
        shadow_fall_d = shadow_fall_q;

        if (swap) begin
            pending_d = 1'b0;
        end

        if (s1_vld_q) begin
            shadow_rise_d[idx_q] = s1_rise_q;
            shadow_fall_d[idx_q] = s1_fall_q;
            if (idx_q == '0) begin
                pending_d = 1'b0;
            end
            if (idx_q == LAST_IDX) begin
                idx_d     = '0;
                pending_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Output uses the post-swap table so the new frame owns the whole period starting at tick 0.
    always_comb begin
        active_rise_d = active_rise_q;
        active_fall_d = active_fall_q;
        if (swap) begin
            active_rise_d = shadow_rise_q;
            active_fall_d = shadow_fall_q;
        end

        pwm_out_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pwm_out_d[i] = edge_hit(active_rise_d[i], active_fall_d[i], bus.pwm_time);
        end

        updated_d = swap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_rise_q <= '0;
            s1_fall_q <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
            pwm_out_q <= '0;
            updated_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                shadow_rise_q[i] <= '0;
                shadow_fall_q[i] <= '0;
                active_rise_q[i] <= '0;
                active_fall_q[i] <= '0;
            end
        end else begin
            s1_vld_q      <= s1_vld_d;
            s1_rise_q     <= s1_rise_d;
            s1_fall_q     <= s1_fall_d;
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            pwm_out_q     <= pwm_out_d;
            updated_q     <= updated_d;
            shadow_rise_q <= shadow_rise_d;
            shadow_fall_q <= shadow_fall_d;
            active_rise_q <= active_rise_d;
            active_fall_q <= active_fall_d;
        end
    end

    assign bus.pwm_out = pwm_out_q;
    assign bus.updated = updated_q;

endmodule

// File: tb/tb_pwm_timing_generator.sv
// Scoreboard bench: the stimulus pushes expected PWM vectors per driven tick; a monitor compares them.
module tb_pwm_timing_generator;
    localparam int DEPTH = 249;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    pwm_timing_generator_if #(.DEPTH(DEPTH)) bus ();

    pwm_timing_generator #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int               due;
        logic [DEPTH-1:0] pwm;
        logic             upd;
        int               tid;
        int               t;
    } exp_t;

    exp_t sb[$];

    int m_rise [DEPTH];
    int m_fall [DEPTH];
    int fr_pw  [DEPTH];
    int fr_ph  [DEPTH];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic ref_bit(input int r, input int f, input int t);
        if (r < f) return (t >= r && t < f);
        if (r > f) return (t >= r || t < f);
        return 1'b0;
    endfunction

    function automatic logic [DEPTH-1:0] model_vec(input int t);
        logic [DEPTH-1:0] v;
        for (int i = 0; i < DEPTH; i++) v[i] = ref_bit(m_rise[i], m_fall[i], t);
        return v;
    endfunction

    task automatic check_vec(input string name, input int tid, input int t,
                             input logic [DEPTH-1:0] act, input logic [DEPTH-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s test=%0d t=%0d got=%h want=%h", name, tid, t, act, want);
        end
    endtask

    task automatic check_bit(input string name, input int tid, input int t,
                             input logic act, input logic want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s test=%0d t=%0d got=%b want=%b", name, tid, t, act, want);
        end
    endtask

    // Monitor: every cycle, compare whatever the DUT presents against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                if (e.due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missed_sample test=%0d t=%0d got=cycle%0d want=cycle%0d", e.tid, e.t, cyc, e.due);
                end else begin
                    check_vec("pwm_out", e.tid, e.t, bus.pwm_out, e.pwm);
                    check_bit("updated", e.tid, e.t, bus.updated, e.upd);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input int t, input bit v, input int pw, input int ph);
        @(posedge clk);
        #1;
        bus.pwm_time       = 9'(t);
        bus.din_vld        = v;
        bus.pulse_width_in = 9'(pw);
        bus.phase_in       = 8'(ph);
    endtask

    task automatic send_frame(input int count, input bit gaps, input int t_hold);
        for (int i = 0; i < count; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) drive(t_hold, 1'b0, 0, 0);
            drive(t_hold, 1'b1, fr_pw[i], fr_ph[i]);
        end
        if (count == DEPTH) begin
            for (int k = 0; k < 3; k++) drive(t_hold, 1'b0, 0, 0);
        end
    endtask

    // Sweep ticks t0..511; tick 0 is repeated 'hold0' times and only its first pass may expect 'updated'.
    task automatic sweep(input int tid, input int t0, input bit upd0, input int hold0);
        exp_t e;
        for (int t = t0; t < 512; t++) begin
            for (int h = 0; h < ((t == 0) ? hold0 : 1); h++) begin
                drive(t, 1'b0, 0, 0);
                e.due = cyc + 1;
                e.pwm = model_vec(t);
                e.upd = (t == 0) && (h == 0) && upd0;
                e.tid = tid;
                e.t   = t;
                sb.push_back(e);
            end
        end
    endtask

    task automatic set_model(input int i, input int r, input int f);
        m_rise[i] = r;
        m_fall[i] = f;
    endtask

    initial begin
        int pws;
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        bus.pwm_time       = 9'd0;
        bus.din_vld        = 1'b0;
        bus.pulse_width_in = 9'd0;
        bus.phase_in       = 8'd0;
        for (int i = 0; i < DEPTH; i++) set_model(i, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: reset state, full sweep all low, no update pulse
        sweep(1, 0, 1'b0, 1);

        // 2: PW=100 PHASE=64 -> 78..177; then a second period holding tick 0 must not pulse again
        for (int i = 0; i < DEPTH; i++) begin fr_pw[i] = 100; fr_ph[i] = 64; end
        send_frame(DEPTH, 1'b0, 5);
        for (int i = 0; i < DEPTH; i++) set_model(i, 78, 178);
        sweep(2, 0, 1'b1, 1);
        sweep(2, 0, 1'b0, 3);

        // 3: wrap (PW=256,PH=0), single tick (PW=1,PH=0), zero width (PW=0,PH=77)
        for (int i = 0; i < DEPTH; i++) begin
            case (i % 3)
                0: begin fr_pw[i] = 256; fr_ph[i] = 0;  set_model(i, 384, 128); end
                1: begin fr_pw[i] = 1;   fr_ph[i] = 0;  set_model(i, 0, 1);     end
                default: begin fr_pw[i] = 0; fr_ph[i] = 77; set_model(i, 154, 154); end
            endcase
        end
        send_frame(DEPTH, 1'b0, 5);
        sweep(3, 0, 1'b1, 1);

        // 4: PW=300 saturates to 256 (PH=10 -> 404/148); PW=0 at PH=200 stays low
        for (int i = 0; i < DEPTH; i++) begin
            if (i % 2 == 0) begin fr_pw[i] = 300; fr_ph[i] = 10;  set_model(i, 404, 148); end
            else            begin fr_pw[i] = 0;   fr_ph[i] = 200; set_model(i, 400, 400); end
        end
        send_frame(DEPTH, 1'b0, 5);
        sweep(4, 0, 1'b1, 1);

        // 5: frame A completes, frame B (with gaps) overtakes it before tick 0
        for (int i = 0; i < DEPTH; i++) begin fr_pw[i] = 50; fr_ph[i] = 20; end
        send_frame(DEPTH, 1'b0, 5);
        for (int i = 0; i < DEPTH; i++) begin fr_pw[i] = 51; fr_ph[i] = 100; end
        send_frame(DEPTH, 1'b1, 5);
        for (int i = 0; i < DEPTH; i++) set_model(i, 175, 226);
        sweep(5, 0, 1'b1, 1);

        // 6: reset after 100 samples while frame B is high at tick 200
        for (int i = 0; i < DEPTH; i++) begin fr_pw[i] = 20; fr_ph[i] = 30; end
        send_frame(100, 1'b0, 200);
        drive(200, 1'b0, 0, 0);
        #2;
        check_vec("pre_reset_pwm", 6, 200, bus.pwm_out, {DEPTH{1'b1}});
        rst = 1'b1;
        #1;
        check_vec("reset_pwm", 6, 200, bus.pwm_out, {DEPTH{1'b0}});
        check_bit("reset_updated", 6, 200, bus.updated, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) set_model(i, 0, 0);

        for (int i = 0; i < DEPTH; i++) begin
            fr_pw[i] = $urandom_range(0, 300);
            fr_ph[i] = $urandom_range(0, 255);
        end
        send_frame(DEPTH, 1'b0, 5);
        sweep(6, 1, 1'b0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            pws = (fr_pw[i] > 256) ? 256 : fr_pw[i];
            set_model(i, ((2 * fr_ph[i] - pws / 2) % 512 + 512) % 512,
                         (2 * fr_ph[i] + (pws + 1) / 2) % 512);
        end
        sweep(6, 0, 1'b1, 1);

        repeat (4) drive(5, 1'b0, 0, 0);
        @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
